// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer reader.
package vga_pkg;

    localparam int unsigned LIM_160  = 32'd19200;
    localparam int unsigned LIM_320  = 32'd76800;
    localparam int unsigned LIM_640  = 32'd307200;

    localparam int unsigned LINE_160 = 32'd160;
    localparam int unsigned LINE_320 = 32'd320;
    localparam int unsigned LINE_640 = 32'd640;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_SCAN = 2'd2
    } fb_state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // 160x120 takes priority over 320x240.
    function automatic logic [31:0] pix_limit(input logic rez_160, input logic rez_320);
        if (rez_160) begin
            return LIM_160;
        end else if (rez_320) begin
            return LIM_320;
        end else begin
            return LIM_640;
        end
    endfunction

    function automatic logic [31:0] line_width(input logic rez_160, input logic rez_320);
        if (rez_160) begin
            return LINE_160;
        end else if (rez_320) begin
            return LINE_320;
        end else begin
            return LINE_640;
        end
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// RD_LAT-deep shift register for the {activeArea, Hsync, Vsync} bundle,
// with a per-bit reset value so syncs come out of reset inactive (high).
module vga_sync_delay #(
    parameter int             DEPTH   = 1,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_r [DEPTH];

    // Shift the bundle one stage per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RST_VAL;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer read address generator and RGB444 output stage for VGA.
// Optional FB_TEST_PATTERN_EN replaces rd_data with an 8-bar colour pattern.
module vga_fb_reader
    import vga_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 1
) (
    input  logic              CLK25,
    input  logic              RST,
    input  logic              rez_160x120,
    input  logic              rez_320x240,
    input  logic              activeArea,
    input  logic              Hsync,
    input  logic              Vsync,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              frame_start,
    output logic              ovf
);

    fb_state_t         state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] lim_m1_s;
    logic              fs_r;
    logic              ovf_r;
    logic              full_r;
    logic [2:0]        dly_s;
    rgb444_t           pix_s;
    rgb444_t           pix_r;
    logic              hs_r;
    logic              vs_r;

    assign lim_m1_s = ADDR_W'(pix_limit(rez_160x120, rez_320x240) - 32'd1);

    // Frame FSM and read-address counter. full_r marks that the pixel at
    // LIM-1 has been consumed, so only a further active pixel raises ovf.
    always_ff @(posedge CLK25) begin
        if (RST) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            fs_r    <= 1'b0;
            ovf_r   <= 1'b0;
            full_r  <= 1'b0;
        end else begin
            fs_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    addr_r <= '0;
                    full_r <= 1'b0;
                    if (!Vsync) begin
                        state_r <= ST_SYNC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SYNC: begin
                    addr_r <= '0;
                    full_r <= 1'b0;
                    if (Vsync) begin
                        state_r <= ST_SCAN;
                        fs_r    <= 1'b1;
                    end else begin
                        state_r <= ST_SYNC;
                    end
                end
                ST_SCAN: begin
                    if (!Vsync) begin
                        state_r <= ST_SYNC;
                        addr_r  <= '0;
                        full_r  <= 1'b0;
                    end else if (activeArea) begin
                        if (addr_r < lim_m1_s) begin
                            addr_r <= addr_r + ADDR_W'(1);
                            full_r <= 1'b0;
                        end else begin
                            // Clamp also covers a mode shrink that left addr_r past LIM-1.
                            addr_r <= lim_m1_s;
                            full_r <= 1'b1;
                            if (full_r || (addr_r != lim_m1_s)) begin
                                ovf_r <= 1'b1;
                            end else begin
                                ovf_r <= ovf_r;
                            end
                        end
                    end else begin
                        addr_r <= addr_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    addr_r  <= '0;
                    full_r  <= 1'b0;
                end
            endcase
        end
    end

    vga_sync_delay #(
        .DEPTH   (RD_LAT),
        .W       (3),
        .RST_VAL (3'b011)
    ) u_sync_delay (
        .clk  (CLK25),
        .rst  (RST),
        .din  ({activeArea, Hsync, Vsync}),
        .dout (dly_s)
    );

`ifdef FB_TEST_PATTERN_EN
    logic [9:0] bar_cnt_r;
    logic [2:0] bar_idx_r;
    logic [9:0] bar_last_s;

    assign bar_last_s = 10'(line_width(rez_160x120, rez_320x240) / 32'd8 - 32'd1);

    // Horizontal bar counter, restarted whenever the delayed active bit is low.
    always_ff @(posedge CLK25) begin
        if (RST || !dly_s[2]) begin
            bar_cnt_r <= 10'd0;
            bar_idx_r <= 3'd0;
        end else if (bar_cnt_r == bar_last_s) begin
            bar_cnt_r <= 10'd0;
            bar_idx_r <= bar_idx_r + 3'd1;
        end else begin
            bar_cnt_r <= bar_cnt_r + 10'd1;
            bar_idx_r <= bar_idx_r;
        end
    end

    // Bar order white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        pix_s   = '0;
        pix_s.r = {4{~bar_idx_r[1]}};
        pix_s.g = {4{~bar_idx_r[2]}};
        pix_s.b = {4{~bar_idx_r[0]}};
    end
`else
    assign pix_s = rgb444_t'(rd_data);
`endif

    // Output stage: colour and syncs registered together so they stay aligned.
    always_ff @(posedge CLK25) begin
        if (RST) begin
            pix_r <= '0;
            hs_r  <= 1'b1;
            vs_r  <= 1'b1;
        end else begin
            hs_r <= dly_s[1];
            vs_r <= dly_s[0];
            if (dly_s[2] && (state_r != ST_IDLE)) begin
                pix_r <= pix_s;
            end else begin
                pix_r <= '0;
            end
        end
    end

    assign rd_addr     = addr_r;
    assign vga_r       = pix_r.r;
    assign vga_g       = pix_r.g;
    assign vga_b       = pix_r.b;
    assign vga_hs      = hs_r;
    assign vga_vs      = vs_r;
    assign frame_start = fs_r;
    assign ovf         = ovf_r;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: one instance with RD_LAT=1, one with RD_LAT=2.
module tb_vga_fb_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rez160;
    logic        rez320;
    logic        act;
    logic        hs;
    logic        vs;
    logic [11:0] data1;
    logic [11:0] data2;

    logic [18:0] addr1, addr2;
    logic [3:0]  r1, g1, b1, r2, g2, b2;
    logic        hs1, vs1, hs2, vs2, fs1, fs2, ovf1, ovf2;

    int n_chk  = 0;
    int n_fail = 0;
    int fs_cnt = 0;

    always #20 clk = ~clk;

    vga_fb_reader #(.ADDR_W(19), .RD_LAT(1)) dut1 (
        .CLK25(clk), .RST(rst), .rez_160x120(rez160), .rez_320x240(rez320),
        .activeArea(act), .Hsync(hs), .Vsync(vs), .rd_addr(addr1), .rd_data(data1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1),
        .frame_start(fs1), .ovf(ovf1)
    );

    vga_fb_reader #(.ADDR_W(19), .RD_LAT(2)) dut2 (
        .CLK25(clk), .RST(rst), .rez_160x120(rez160), .rez_320x240(rez320),
        .activeArea(act), .Hsync(hs), .Vsync(vs), .rd_addr(addr2), .rd_data(data2),
        .vga_r(r2), .vga_g(g2), .vga_b(b2), .vga_hs(hs2), .vga_vs(vs2),
        .frame_start(fs2), .ovf(ovf2)
    );

    typedef struct {
        logic        act;
        logic        hs;
        logic [11:0] data;
        logic [11:0] exp_rgb;
        logic        exp_hs;
        logic [18:0] exp_addr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance one clock; outputs are then stable for the new cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (fs1 === 1'b1) fs_cnt++;
    endtask

    vec_t vt [10];

    initial begin
        // RD_LAT=2 pixel-path vectors: rgb[k] = act[k-3] ? data[k-1] : 0, hs_out[k] = hs[k-3]
        vt[0] = '{1'b1, 1'b1, 12'h111, 12'h000, 1'b1, 19'd0};
        vt[1] = '{1'b1, 1'b1, 12'h222, 12'h000, 1'b1, 19'd1};
        vt[2] = '{1'b0, 1'b0, 12'h333, 12'h000, 1'b1, 19'd2};
        vt[3] = '{1'b1, 1'b0, 12'h444, 12'h333, 1'b1, 19'd2};
        vt[4] = '{1'b0, 1'b1, 12'h555, 12'h444, 1'b1, 19'd3};
        vt[5] = '{1'b0, 1'b1, 12'h666, 12'h000, 1'b0, 19'd3};
        vt[6] = '{1'b0, 1'b1, 12'h777, 12'h666, 1'b0, 19'd3};
        vt[7] = '{1'b0, 1'b1, 12'h888, 12'h000, 1'b1, 19'd3};
        vt[8] = '{1'b0, 1'b1, 12'h999, 12'h000, 1'b1, 19'd3};
        vt[9] = '{1'b0, 1'b1, 12'hAAA, 12'h000, 1'b1, 19'd3};

        rst = 1'b1; rez160 = 1'b0; rez320 = 1'b0;
        act = 1'b0; hs = 1'b1; vs = 1'b1; data1 = 12'h000; data2 = 12'h000;
        #1;
        repeat (3) cyc();

        // Reset state
        chk("rst_addr1", 32'(addr1), 32'd0);
        chk("rst_addr2", 32'(addr2), 32'd0);
        chk("rst_rgb1", 32'({r1, g1, b1}), 32'd0);
        chk("rst_hs_vs1", 32'({hs1, vs1}), 32'd3);
        chk("rst_hs_vs2", 32'({hs2, vs2}), 32'd3);
        chk("rst_fs_ovf", 32'({fs1, ovf1, fs2, ovf2}), 32'd0);

        // IDLE with Vsync high: address held, pixel black despite activity
        rst = 1'b0; act = 1'b1; data1 = 12'hFFF; data2 = 12'hFFF;
        repeat (5) cyc();
        chk("idle_addr", 32'(addr1), 32'd0);
        chk("idle_rgb1", 32'({r1, g1, b1}), 32'd0);
        chk("idle_rgb2", 32'({r2, g2, b2}), 32'd0);
        act = 1'b0;

        // Full 160x120 frame
        rez160 = 1'b1;
        vs = 1'b0; cyc(); cyc();
        fs_cnt = 0;
        vs = 1'b1; cyc();
        chk("fs_pulse", 32'({fs1, fs2}), 32'd3);
        cyc();
        chk("fs_one_cycle", 32'(fs1), 32'd0);
        for (int line = 0; line < 120; line++) begin
            hs = 1'b0; repeat (4) cyc();
            hs = 1'b1; repeat (8) cyc();
            act = 1'b1;
            for (int px = 0; px < 160; px++) begin
                if (px == 0)   chk("line_first", 32'(addr1), 32'(line * 160));
                if (px == 159) chk("line_last", 32'(addr1), 32'(line * 160 + 159));
                cyc();
            end
            act = 1'b0;
        end
        repeat (5) cyc();
        chk("frame_end_addr1", 32'(addr1), 32'd19199);
        chk("frame_end_addr2", 32'(addr2), 32'd19199);
        chk("frame_ovf", 32'(ovf1), 32'd0);
        chk("frame_fs_count", 32'(fs_cnt), 32'd1);
        vs = 1'b0; cyc();
        chk("sync_clear", 32'(addr1), 32'd0);
        cyc();
        vs = 1'b1; cyc();

        // Active pixel coinciding with Vsync falling: transition wins
        act = 1'b1; repeat (10) cyc();
        chk("pre_collide", 32'(addr1), 32'd10);
        vs = 1'b0; cyc();
        chk("collide_addr", 32'(addr1), 32'd0);
        act = 1'b0; vs = 1'b1; cyc(); cyc();

        // Both rez high -> 19200 limit, overflow, then widen to 320x240
        rez160 = 1'b1; rez320 = 1'b1; act = 1'b1;
        repeat (19200) cyc();
        chk("lim_addr", 32'(addr1), 32'd19199);
        chk("lim_no_ovf", 32'(ovf1), 32'd0);
        cyc();
        chk("ovf_set", 32'(ovf1), 32'd1);
        chk("ovf_hold_addr", 32'(addr1), 32'd19199);
        repeat (99) cyc();
        chk("ovf_sat_addr", 32'(addr2), 32'd19199);
        rez160 = 1'b0;
        repeat (100) cyc();
        chk("mode_grow_addr", 32'(addr1), 32'd19299);
        act = 1'b0; vs = 1'b0; cyc(); cyc();
        chk("ovf_sticky", 32'({ovf1, ovf2}), 32'd3);
        chk("ovf_sync_addr", 32'(addr1), 32'd0);

        // Table-driven pixel path, 640 mode
        rez320 = 1'b0; vs = 1'b1;
        repeat (4) cyc();
        for (int k = 0; k < 10; k++) begin
            act = vt[k].act; hs = vt[k].hs; data1 = vt[k].data; data2 = vt[k].data;
            chk("vec_addr", 32'(addr2), 32'(vt[k].exp_addr));
            chk("vec_hs", 32'(hs2), 32'(vt[k].exp_hs));
`ifndef FB_TEST_PATTERN_EN
            chk("vec_rgb", 32'({r2, g2, b2}), 32'(vt[k].exp_rgb));
`endif
            cyc();
        end

        // Single-cycle pulse: RD_LAT=2 -> 3 cycles, RD_LAT=1 -> 2 cycles
        act = 1'b0; hs = 1'b1; data1 = 12'hA5C; data2 = 12'hA5C;
        repeat (4) cyc();
        act = 1'b1; hs = 1'b0; vs = 1'b0; cyc();
        act = 1'b0;
        chk("pulse_p1_rgb2", 32'({r2, g2, b2}), 32'd0);
        cyc();
        chk("pulse_p2_rgb2", 32'({r2, g2, b2}), 32'd0);
        chk("pulse_p2_sync2", 32'({hs2, vs2}), 32'd3);
`ifndef FB_TEST_PATTERN_EN
        chk("pulse_p2_rgb1", 32'({r1, g1, b1}), 32'hA5C);
`endif
        cyc();
`ifndef FB_TEST_PATTERN_EN
        chk("pulse_p3_rgb2", 32'({r2, g2, b2}), 32'hA5C);
`endif
        chk("pulse_p3_sync2", 32'({hs2, vs2}), 32'd0);
        chk("pulse_p3_rgb1", 32'({r1, g1, b1}), 32'd0);
        cyc();
        chk("pulse_p4_rgb2", 32'({r2, g2, b2}), 32'd0);
        hs = 1'b1;

        // Reset mid-line at address 1000
        vs = 1'b1; cyc();
        data1 = 12'hFFF; data2 = 12'hFFF; act = 1'b1;
        repeat (1000) cyc();
        chk("pre_rst_addr", 32'(addr1), 32'd1000);
`ifndef FB_TEST_PATTERN_EN
        chk("pre_rst_rgb1", 32'({r1, g1, b1}), 32'hFFF);
`endif
        rst = 1'b1; cyc();
        chk("mid_rst_addr", 32'(addr1), 32'd0);
        chk("mid_rst_rgb", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);
        rst = 1'b0; fs_cnt = 0;
        repeat (5) cyc();
        chk("post_rst_idle_addr", 32'(addr1), 32'd0);
        vs = 1'b0; cyc(); cyc();
        chk("post_rst_no_fs", 32'(fs_cnt), 32'd0);
        vs = 1'b1; cyc();
        chk("post_rst_fs", 32'(fs1), 32'd1);
        act = 1'b0;

`ifdef FB_TEST_PATTERN_EN
        // Colour bars in 640 mode, RD_LAT=1: pixel j visible in cycle j+2
        repeat (4) cyc();
        for (int px = 0; px < 642; px++) begin
            act = (px < 640) ? 1'b1 : 1'b0;
            cyc();
            if (px == 1)   chk("bar_px0", 32'({r1, g1, b1}), 32'hFFF);
            if (px == 81)  chk("bar_px80", 32'({r1, g1, b1}), 32'hFF0);
            if (px == 561) chk("bar_px560", 32'({r1, g1, b1}), 32'h000);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
